alu_8bit: RTL and testbench

- Registered 8-bit arithmetic/logic unit with 16 operations selected by a 4-bit opcode.
- Operands and opcode are combinational inputs, sampled on the rising clock edge.
- Result and carry flag are registered, so they appear one clock after sampling.
- Used as a single-cycle execution datapath element; it has no handshake.

---
 rtl/alu_8bit.sv | 86 ++++++++
 tb/tb_alu_8bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: 16 operations selected by ALU_Sel, result and carry
// captured on the rising clock edge, one cycle after the operands are sampled.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ROL  = 4'd6,
    OP_ROR  = 4'd7,
    OP_AND  = 4'd8,
    OP_OR   = 4'd9,
    OP_XOR  = 4'd10,
    OP_NOR  = 4'd11,
    OP_NAND = 4'd12,
    OP_XNOR = 4'd13,
    OP_GT   = 4'd14,
    OP_EQ   = 4'd15
  } op_e;

  op_e              op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             carry;

  assign op  = op_e'(ALU_Sel);
  assign sum = {1'b0, A} + {1'b0, B};

  // NOTE: every output of this block gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    result = sum[WIDTH-1:0];
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB:  result = A - B;
      OP_MUL:  result = A * B;  // low half of the product only
      OP_DIV:  result = (B == '0) ? '1 : A / B;
      OP_SHL:  result = {A[WIDTH-2:0], 1'b0};
      OP_SHR:  result = {1'b0, A[WIDTH-1:1]};
      OP_ROL:  result = {A[WIDTH-2:0], A[WIDTH-1]};
      OP_ROR:  result = {A[0], A[WIDTH-1:1]};
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_NAND: result = ~(A & B);
      OP_XNOR: result = ~(A ^ B);
      OP_GT:   result = {{(WIDTH-1){1'b0}}, (A > B)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (A == B)};
      default: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
    end else begin
      ALU_Out  <= result;
      CarryOut <= carry;
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Scoreboard bench for alu_8bit: directed vectors plus randomized traffic
// against an arithmetic reference model; a monitor checks every output cycle.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [3:0] ALU_Sel = 4'd0;
  logic [7:0] ALU_Out;
  logic       CarryOut;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] out;
    logic       carry;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] out;
    logic       carry;
  } vec_t;

  alu_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .ALU_Sel  (ALU_Sel),
    .ALU_Out  (ALU_Out),
    .CarryOut (CarryOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got_out, input logic got_c,
                       input logic [7:0] exp_out, input logic exp_c);
    n_checks++;
    if (got_out !== exp_out || got_c !== exp_c) begin
      n_errors++;
      $display("FAIL %s: got out=%02h carry=%0b, expected out=%02h carry=%0b",
               tag, got_out, got_c, exp_out, exp_c);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned values.
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                                output logic [7:0] r, output logic c);
    int ai = int'(a);
    int bi = int'(b);
    int v;
    c = 1'b0;
    case (sel)
      4'd0:  begin v = ai + bi; c = (v > 255); end
      4'd1:  v = ai - bi + 256;
      4'd2:  v = ai * bi;
      4'd3:  v = (bi == 0) ? 255 : ai / bi;
      4'd4:  v = ai * 2;
      4'd5:  v = ai / 2;
      4'd6:  v = (ai * 2) % 256 + ai / 128;
      4'd7:  v = ai / 2 + (ai % 2) * 128;
      4'd8:  v = int'(a & b);
      4'd9:  v = int'(a | b);
      4'd10: v = int'(a ^ b);
      4'd11: v = 255 - int'(a | b);
      4'd12: v = 255 - int'(a & b);
      4'd13: v = 255 - int'(a ^ b);
      4'd14: v = (ai > bi) ? 1 : 0;
      default: v = (ai == bi) ? 1 : 0;
    endcase
    r = 8'(v % 256);
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic [7:0] exp_out, input logic exp_c, input string tag);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = sel;
    e.out = exp_out;
    e.carry = exp_c;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic issue_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                             input string tag);
    logic [7:0] r;
    logic       c;
    model(a, b, sel, r, c);
    issue(a, b, sel, r, c, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d results never checked, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: with no handshake, every non-reset edge presents exactly one
  // result, which must match the oldest outstanding expectation.
  always @(posedge clk) begin
    if (!rst && exp_q.size() != 0) begin
      exp_t e;
      #1;
      e = exp_q.pop_front();
      check(e.tag, ALU_Out, CarryOut, e.out, e.carry);
    end
  end

  vec_t dir[$];

  initial begin
    // Full sweep with A=0x6A, B=0x3B, then carry, wrap, divide, rotate, compare.
    dir = '{
      '{8'h6A, 8'h3B, 4'd0,  8'hA5, 1'b0}, '{8'h6A, 8'h3B, 4'd1,  8'h2F, 1'b0},
      '{8'h6A, 8'h3B, 4'd2,  8'h6E, 1'b0}, '{8'h6A, 8'h3B, 4'd3,  8'h01, 1'b0},
      '{8'h6A, 8'h3B, 4'd4,  8'hD4, 1'b0}, '{8'h6A, 8'h3B, 4'd5,  8'h35, 1'b0},
      '{8'h6A, 8'h3B, 4'd6,  8'hD4, 1'b0}, '{8'h6A, 8'h3B, 4'd7,  8'h35, 1'b0},
      '{8'h6A, 8'h3B, 4'd8,  8'h2A, 1'b0}, '{8'h6A, 8'h3B, 4'd9,  8'h7B, 1'b0},
      '{8'h6A, 8'h3B, 4'd10, 8'h51, 1'b0}, '{8'h6A, 8'h3B, 4'd11, 8'h84, 1'b0},
      '{8'h6A, 8'h3B, 4'd12, 8'hD5, 1'b0}, '{8'h6A, 8'h3B, 4'd13, 8'hAE, 1'b0},
      '{8'h6A, 8'h3B, 4'd14, 8'h01, 1'b0}, '{8'h6A, 8'h3B, 4'd15, 8'h00, 1'b0},
      '{8'hFF, 8'h01, 4'd0,  8'h00, 1'b1}, '{8'hFF, 8'h01, 4'd1,  8'hFE, 1'b0},
      '{8'h00, 8'h01, 4'd1,  8'hFF, 1'b0}, '{8'hFF, 8'hFF, 4'd2,  8'h01, 1'b0},
      '{8'h55, 8'h00, 4'd3,  8'hFF, 1'b0}, '{8'h81, 8'h00, 4'd6,  8'h03, 1'b0},
      '{8'h81, 8'h00, 4'd7,  8'hC0, 1'b0}, '{8'h3C, 8'h3C, 4'd14, 8'h00, 1'b0},
      '{8'h3C, 8'h3C, 4'd15, 8'h01, 1'b0}
    };

    #1;
    check("reset_at_start", ALU_Out, CarryOut, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", ALU_Out, CarryOut, 8'h00, 1'b0);
    #2 rst = 1'b0;

    issue(8'h10, 8'h01, 4'd0, 8'h11, 1'b0, "first_after_reset");

    // Back-to-back directed vectors: any extra latency or bubble misaligns the queue.
    foreach (dir[i])
      issue(dir[i].a, dir[i].b, dir[i].sel, dir[i].out, dir[i].carry,
            $sformatf("dir%0d_sel%0d", i, dir[i].sel));
    drain();

    // Asynchronous reset mid-cycle while outputs are non-zero.
    issue(8'hFF, 8'h02, 4'd0, 8'h01, 1'b1, "pre_reset_value");
    drain();
    #3 rst = 1'b1;
    #1;
    check("async_reset_no_edge", ALU_Out, CarryOut, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check("reset_holds_zero", ALU_Out, CarryOut, 8'h00, 1'b0);
    #2 rst = 1'b0;
    issue(8'h10, 8'h01, 4'd0, 8'h11, 1'b0, "release_first_edge");
    drain();

    // Randomized traffic, with divide-by-zero and equal operands forced often.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] sel;
      int         kind;
      a    = 8'($urandom_range(0, 255));
      b    = 8'($urandom_range(0, 255));
      sel  = 4'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 7));
      if (kind == 0) b = 8'h00;
      else if (kind == 1) b = a;
      issue_model(a, b, sel, $sformatf("rand%0d_a%02h_b%02h_sel%0d", i, a, b, sel));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
